equalizer_8band: RTL and testbench

Eight-band audio graphic equalizer for a 16-bit mono sample stream. One time-multiplexed FIR filter per band splits the input: a low-pass below 1 kHz, six 1 kHz-wide band-passes from 1 to 7 kHz, and a high-pass above 7 kHz. Each band output is scaled by a programmable gain, and the scaled bands are summed into one saturated output. The block sits between the audio sample source and the DAC/output path and processes one sample per 64-cycle enabled frame.

---
 rtl/equalizer_8band.sv | 192 +++++++++++++++++++
 tb/tb_equalizer_8band.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/equalizer_8band.sv
// Eight-band time-multiplexed FIR graphic equalizer: each band evaluates one tap per enabled
// clock over a 64-phase frame, then gains are applied and the bands summed with saturation.
module equalizer_8band #(
  parameter int FILTER_IN_BITS    = 16,
  parameter int FILTER_OUT_BITS   = 16,
  parameter int NUMBER_OF_FILTERS = 8,
  parameter int GAIN_BITS         = 8,
  parameter int GAIN_FRAC_BITS    = 2,
  parameter int TAPS              = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clk_enable,
  input  logic                                   amplifier_enable,
  input  logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] amplifier_gains,
  input  logic signed [FILTER_IN_BITS-1:0]       filter_in,
  output logic signed [FILTER_OUT_BITS-1:0]      filter_out,
  output logic signed [FILTER_OUT_BITS-1:0]      filter_lpf_1000hz,
  output logic signed [FILTER_OUT_BITS-1:0]      filter_bpf_1000hz2000hz,
  output logic signed [FILTER_OUT_BITS-1:0]      filter_bpf_2000hz3000hz,
  output logic signed [FILTER_OUT_BITS-1:0]      filter_bpf_3000hz4000hz,
  output logic signed [FILTER_OUT_BITS-1:0]      filter_bpf_4000hz5000hz,
  output logic signed [FILTER_OUT_BITS-1:0]      filter_bpf_5000hz6000hz,
  output logic signed [FILTER_OUT_BITS-1:0]      filter_bpf_6000hz7000hz,
  output logic signed [FILTER_OUT_BITS-1:0]      filter_hpf_7000hz
);

  localparam int PHASE_BITS  = $clog2(TAPS);
  localparam int COEF_BITS   = 16;
  localparam int COEF_FRAC   = 15;
  localparam int PROD_BITS   = FILTER_IN_BITS + COEF_BITS;
  localparam int ACC_BITS    = 40;
  localparam int GAINED_BITS = FILTER_OUT_BITS + GAIN_BITS;
  localparam int SUM_BITS    = FILTER_OUT_BITS + $clog2(NUMBER_OF_FILTERS);
  localparam logic [PHASE_BITS-1:0] LAST_PHASE = PHASE_BITS'(TAPS - 1);
  localparam logic signed [ACC_BITS-1:0] OUT_MAX =
    {{(ACC_BITS-FILTER_OUT_BITS+1){1'b0}}, {(FILTER_OUT_BITS-1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] OUT_MIN =
    {{(ACC_BITS-FILTER_OUT_BITS+1){1'b1}}, {(FILTER_OUT_BITS-1){1'b0}}};

  function automatic int quarter_sine(input int k);
    int s;
    case (k)
      0:  s = 0;
      1:  s = 3212;
      2:  s = 6393;
      3:  s = 9512;
      4:  s = 12539;
      5:  s = 15446;
      6:  s = 18204;
      7:  s = 20787;
      8:  s = 23170;
      9:  s = 25329;
      10: s = 27245;
      11: s = 28898;
      12: s = 30273;
      13: s = 31356;
      14: s = 32137;
      15: s = 32609;
      16: s = 32767;
      default: s = 0;
    endcase
    return s;
  endfunction

  // Angle a is in units of pi/32, so one full turn is 64 steps.
  function automatic int cosine_q15(input int a);
    int m;
    int c;
    m = a & 63;
    if (m <= 16)      c = quarter_sine(16 - m);
    else if (m <= 32) c = -quarter_sine(m - 16);
    else if (m <= 48) c = -quarter_sine(48 - m);
    else              c = quarter_sine(m - 48);
    return c;
  endfunction

  // Triangular-windowed cosine prototypes (band 0 centred at DC); band-pass tables are trimmed
  // at the centre taps so their DC sum is exactly zero and DC leaks only through band 0.
  function automatic logic [TAPS*COEF_BITS-1:0] band_table(input int band);
    logic [TAPS*COEF_BITS-1:0] tbl;
    int c [TAPS];
    int freq;
    int w;
    int total;
    freq  = (band == 0) ? 0 : 2 * band + 1;
    total = 0;
    for (int t = 0; t < TAPS; t++) begin
      w     = (t < TAPS / 2) ? t + 1 : TAPS - t;
      c[t]  = (cosine_q15(freq * (2 * t - (TAPS - 1))) * w) >>> ((band == 0) ? 10 : 9);
      total = total + c[t];
    end
    if (band != 0) begin
      c[TAPS/2-1] = c[TAPS/2-1] - total / 2;
      c[TAPS/2]   = c[TAPS/2] - (total - total / 2);
    end
    tbl = '0;
    for (int t = 0; t < TAPS; t++) begin
      tbl[t*COEF_BITS +: COEF_BITS] = COEF_BITS'(c[t]);
    end
    return tbl;
  endfunction

  function automatic logic signed [FILTER_OUT_BITS-1:0] saturate(input logic signed [ACC_BITS-1:0] v);
    logic signed [FILTER_OUT_BITS-1:0] r;
    if (v > OUT_MAX)      r = {1'b0, {(FILTER_OUT_BITS-1){1'b1}}};
    else if (v < OUT_MIN) r = {1'b1, {(FILTER_OUT_BITS-1){1'b0}}};
    else                  r = v[FILTER_OUT_BITS-1:0];
    return r;
  endfunction

  logic [PHASE_BITS-1:0]             phase_reg;
  logic signed [FILTER_IN_BITS-1:0]  delay_reg [TAPS];
  logic signed [FILTER_IN_BITS-1:0]  tap_sample;
  logic signed [ACC_BITS-1:0]        acc_reg [NUMBER_OF_FILTERS];
  logic signed [ACC_BITS-1:0]        acc_next [NUMBER_OF_FILTERS];
  logic signed [FILTER_OUT_BITS-1:0] band_reg [NUMBER_OF_FILTERS];
  logic signed [FILTER_OUT_BITS-1:0] band_next [NUMBER_OF_FILTERS];
  logic signed [FILTER_OUT_BITS-1:0] gained_next [NUMBER_OF_FILTERS];
  logic signed [SUM_BITS-1:0]        sum_next;
  logic signed [FILTER_OUT_BITS-1:0] filter_out_reg;
  logic                              frame_start;
  logic                              frame_end;

  assign frame_start = (phase_reg == '0);
  assign frame_end   = (phase_reg == LAST_PHASE);

  // Tap 0 is the sample being captured on this edge, so it bypasses the delay line.
  assign tap_sample = frame_start ? filter_in : delay_reg[phase_reg];

  for (genvar gi = 0; gi < NUMBER_OF_FILTERS; gi++) begin : g_band
    localparam logic [TAPS*COEF_BITS-1:0] COEF_TABLE = band_table(gi);
    logic signed [COEF_BITS-1:0]   coef;
    logic signed [PROD_BITS-1:0]   product;
    logic signed [GAIN_BITS-1:0]   gain;
    logic signed [GAINED_BITS-1:0] gained_full;

    assign coef           = COEF_TABLE[phase_reg*COEF_BITS +: COEF_BITS];
    assign product        = tap_sample * coef;
    assign acc_next[gi]   = ACC_BITS'(product) + (frame_start ? '0 : acc_reg[gi]);
    assign band_next[gi]  = saturate(acc_next[gi] >>> COEF_FRAC);
    assign gain           = amplifier_gains[gi*GAIN_BITS +: GAIN_BITS];
    assign gained_full    = band_next[gi] * gain;
    assign gained_next[gi] = amplifier_enable ?
                             saturate(ACC_BITS'(gained_full >>> GAIN_FRAC_BITS)) : band_next[gi];
  end

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < NUMBER_OF_FILTERS; i++) begin
      sum_next = sum_next + SUM_BITS'(gained_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) delay_reg[i] <= '0;
    end else if (clk_enable && frame_start) begin
      delay_reg[0] <= filter_in;
      for (int i = 1; i < TAPS; i++) delay_reg[i] <= delay_reg[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_reg      <= '0;
      filter_out_reg <= '0;
      for (int i = 0; i < NUMBER_OF_FILTERS; i++) begin
        acc_reg[i]  <= '0;
        band_reg[i] <= '0;
      end
    end else if (clk_enable) begin
      phase_reg <= phase_reg + 1'b1;
      for (int i = 0; i < NUMBER_OF_FILTERS; i++) acc_reg[i] <= acc_next[i];
      if (frame_end) begin
        for (int i = 0; i < NUMBER_OF_FILTERS; i++) band_reg[i] <= band_next[i];
        filter_out_reg <= saturate(ACC_BITS'(sum_next));
      end
    end
  end

  assign filter_out              = filter_out_reg;
  assign filter_lpf_1000hz       = band_reg[0];
  assign filter_bpf_1000hz2000hz = band_reg[1];
  assign filter_bpf_2000hz3000hz = band_reg[2];
  assign filter_bpf_3000hz4000hz = band_reg[3];
  assign filter_bpf_4000hz5000hz = band_reg[4];
  assign filter_bpf_5000hz6000hz = band_reg[5];
  assign filter_bpf_6000hz7000hz = band_reg[6];
  assign filter_hpf_7000hz       = band_reg[7];

endmodule

// File: tb/tb_equalizer_8band.sv
// Frame-level self-checking bench for equalizer_8band: a per-frame convolution model over the
// captured-sample history predicts all band outputs and the equalized output.
module tb_equalizer_8band;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               clk_enable = 1'b0;
  logic               amplifier_enable = 1'b0;
  logic [63:0]        amplifier_gains = '0;
  logic signed [15:0] filter_in = '0;
  logic signed [15:0] filter_out;
  logic signed [15:0] dut_band [8];

  equalizer_8band dut (
    .clk                     (clk),
    .rst                     (rst),
    .clk_enable              (clk_enable),
    .amplifier_enable        (amplifier_enable),
    .amplifier_gains         (amplifier_gains),
    .filter_in               (filter_in),
    .filter_out              (filter_out),
    .filter_lpf_1000hz       (dut_band[0]),
    .filter_bpf_1000hz2000hz (dut_band[1]),
    .filter_bpf_2000hz3000hz (dut_band[2]),
    .filter_bpf_3000hz4000hz (dut_band[3]),
    .filter_bpf_4000hz5000hz (dut_band[4]),
    .filter_bpf_5000hz6000hz (dut_band[5]),
    .filter_bpf_6000hz7000hz (dut_band[6]),
    .filter_hpf_7000hz       (dut_band[7])
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int frame_no = 0;
  int h [8][64];
  int xh [$];
  int exp_band [8];
  int exp_out = 0;

  // Shared coefficient table: quarter-wave sine in Q15, triangle window, zero-DC band-passes.
  function automatic void build_coefs();
    int qs [17] = '{0, 3212, 6393, 9512, 12539, 15446, 18204, 20787, 23170,
                    25329, 27245, 28898, 30273, 31356, 32137, 32609, 32767};
    int cos_tab [64];
    for (int a = 0; a < 64; a++) begin
      if (a <= 16)      cos_tab[a] = qs[16-a];
      else if (a <= 32) cos_tab[a] = -qs[a-16];
      else if (a <= 48) cos_tab[a] = -qs[48-a];
      else              cos_tab[a] = qs[a-48];
    end
    for (int b = 0; b < 8; b++) begin
      int freq;
      int total;
      freq  = (b == 0) ? 0 : 2 * b + 1;
      total = 0;
      for (int n = 0; n < 64; n++) begin
        int w;
        w = (n < 32) ? n + 1 : 64 - n;
        h[b][n] = (cos_tab[(freq * (2 * n - 63)) & 63] * w) >>> ((b == 0) ? 10 : 9);
        total += h[b][n];
      end
      if (b != 0) begin
        h[b][31] -= total / 2;
        h[b][32] -= total - total / 2;
      end
    end
  endfunction

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // One frame: newest sample first, y_b = sum_i x[i]*h_b[i] in Q15, then gain and sum.
  function automatic void model_frame(input int s);
    longint total;
    xh.push_front(s);
    if (xh.size() > 64) void'(xh.pop_back());
    total = 0;
    for (int b = 0; b < 8; b++) begin
      longint acc;
      logic signed [7:0] gb;
      int g;
      acc = 0;
      for (int i = 0; i < xh.size(); i++) acc += longint'(xh[i]) * longint'(h[b][i]);
      exp_band[b] = sat16(acc >>> 15);
      gb = amplifier_gains[b*8 +: 8];
      g  = int'(gb);
      if (amplifier_enable) total += sat16((longint'(exp_band[b]) * g) >>> 2);
      else                  total += exp_band[b];
    end
    exp_out = sat16(total);
  endfunction

  function automatic void model_reset();
    xh.delete();
    for (int b = 0; b < 8; b++) exp_band[b] = 0;
    exp_out = 0;
  endfunction

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s frame=%0d got=%0d expected=%0d", tag, frame_no, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int b = 0; b < 8; b++) check_val($sformatf("%s_band%0d", tag, b), int'(dut_band[b]), exp_band[b]);
    check_val($sformatf("%s_out", tag), int'(filter_out), exp_out);
  endtask

  // Runs one 64-phase frame starting at phase 0; optional mid-frame stall and gain change.
  task automatic run_frame(input logic signed [15:0] s, input int stall_at, input int stall_len,
                           input int chg_at, input logic [63:0] chg_gains, input logic chg_amp);
    filter_in  = s;
    clk_enable = 1'b1;
    for (int p = 0; p < 64; p++) begin
      if (p == chg_at) begin
        amplifier_gains  = chg_gains;
        amplifier_enable = chg_amp;
      end
      if (p == stall_at) begin
        clk_enable = 1'b0;
        repeat (stall_len) @(posedge clk);
        #1;
        check_val("stall_hold", int'(filter_out), exp_out);
        clk_enable = 1'b1;
      end
      if (p == 32) check_val("frame_hold", int'(filter_out), exp_out);
      @(posedge clk);
      #1;
      if (p == 0) filter_in = 16'($urandom);
    end
    model_frame(int'(s));
    check_outputs("frame");
    $display("frame %0d in=%0d out=%0d exp=%0d amp=%0b", frame_no, s, filter_out, exp_out, amplifier_enable);
    frame_no++;
  endtask

  function automatic logic signed [15:0] rand_sample();
    logic signed [15:0] r;
    r = 16'($urandom);
    return r >>> $urandom_range(0, 3);
  endfunction

  initial begin
    build_coefs();
    model_reset();

    // Reset state
    #1;
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // A few busy frames, then an asynchronous reset in the middle of a frame
    amplifier_gains  = 64'h0404_0404_0404_0404;
    amplifier_enable = 1'b1;
    for (int k = 0; k < 4; k++) run_frame(rand_sample() | 16'sh4000, -1, 0, -1, '0, 1'b0);
    filter_in  = 16'sd20000;
    clk_enable = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs("midreset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Impulse response at unity gain
    for (int m = 0; m < 67; m++)
      run_frame((m == 0) ? 16'sh7FFF : 16'sh0000, -1, 0, 0, 64'h0404_0404_0404_0404, 1'b1);

    // Per-band gains 0.25 .. 2.0, with a stretch of gain bypass
    for (int m = 0; m < 66; m++)
      run_frame((m == 0) ? 16'sh7FFF : 16'sh0000, -1, 0, 10, 64'h0807_0605_0403_0201,
                (m >= 5 && m < 9) ? 1'b0 : 1'b1);

    // Saturation with DC full scale and maximum gain
    for (int m = 0; m < 66; m++) run_frame(16'sh7FFF, -1, 0, 0, 64'h7F7F_7F7F_7F7F_7F7F, 1'b1);
    check_val("sat_pos", int'(filter_out), 32767);
    for (int m = 0; m < 66; m++) run_frame(16'sh8000, -1, 0, 0, 64'h7F7F_7F7F_7F7F_7F7F, 1'b1);
    check_val("sat_neg", int'(filter_out), -32768);

    // Stalls of 100 cycles mid-frame
    for (int m = 0; m < 6; m++)
      run_frame(rand_sample(), (m == 2 || m == 4) ? 37 : -1, 100, 0, 64'h0506_0708_0403_0201, 1'b1);

    // Long random run with occasional gain changes and stalls
    for (int m = 0; m < 400; m++) begin
      int chg;
      int stall;
      chg   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : -1;
      stall = ($urandom_range(0, 31) == 0) ? int'($urandom_range(1, 62)) : -1;
      run_frame(rand_sample(), stall, int'($urandom_range(1, 100)), chg,
                {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
